// File: rtl/wr_arb_pkg.sv
// wr_arb_pkg: shared widths and types for the CCI write-request arbiter.
package wr_arb_pkg;

  localparam int CL_DATA_W        = 512;  // cache-line payload width
  localparam int CL_BYTE_IDX_BITS = 6;    // byte offset bits within a cache line
  localparam int STATS_W          = 32;   // per-channel issued-line counter width

  // Outstanding-write counter per channel; MAX_OUT is limited to 255.
  typedef logic [7:0] out_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req_i starting at
// ptr_i and wrapping; returns one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 vld_o
);

  localparam int W = $clog2(N);

  logic [W-1:0] cand;

  // First requester at or after the pointer wins; N is a power of two so the
  // index addition wraps naturally.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + W'(k);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = vld_o;
  end

endmodule

// File: rtl/wr_req_arbiter.sv
// wr_req_arbiter: merges NUM_CH write-request streams onto the CCI write
// port with round-robin arbitration, per-channel outstanding-write credits
// and FIU almost-full back-pressure; routes responses back by mdata channel
// bits. Optional per-channel grant counters are built when WR_ARB_STATS_EN
// is defined; otherwise stats is tied to zero.
import wr_arb_pkg::*;

module wr_req_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 48,
  parameter int MDATA_W = 16,
  parameter int MAX_OUT = 64,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req_valid,
  output logic [NUM_CH-1:0]              ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_req_addr,
  input  logic [NUM_CH*CL_DATA_W-1:0]    ch_req_data,
  output logic [NUM_CH-1:0]              ch_wr_ack,
  output logic [NUM_CH-1:0]              ch_busy,
  input  logic                           req_wr_available,
  output logic                           req_wr_en,
  output logic [ADDR_W-1:0]              req_wr_addr,
  output logic [CL_DATA_W-1:0]           req_wr_data,
  output logic [MDATA_W-1:0]             req_wr_mdata,
  input  logic                           resp_wr_valid,
  input  logic [MDATA_W-1:0]             resp_wr_mdata,
  output logic [NUM_CH*STATS_W-1:0]      stats
);

  localparam int       SEQ_W     = MDATA_W - CH_W;
  localparam out_cnt_t MAX_OUT_C = out_cnt_t'(MAX_OUT);

  out_cnt_t              out_cnt_q [NUM_CH];
  out_cnt_t              out_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     req_vec;
  logic [NUM_CH-1:0]     gnt;
  logic [CH_W-1:0]       gnt_idx;
  logic                  gnt_vld;
  logic [NUM_CH-1:0]     rsp_hit;
  logic [CH_W-1:0]       resp_ch;
  logic [CH_W-1:0]       rr_ptr_q;
  logic [SEQ_W-1:0]      seq_q;
  logic                  en_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CL_DATA_W-1:0]  data_q;
  logic [MDATA_W-1:0]    mdata_q;
  logic [NUM_CH-1:0]     ack_q;
  logic                  unused_mdata_hi;

  // Upper mdata bits carry the sequence number and play no part in routing.
  assign unused_mdata_hi = ^resp_wr_mdata[MDATA_W-1:CH_W];
  assign resp_ch         = resp_wr_mdata[CH_W-1:0];

  // Eligibility: valid with a free credit; nothing competes during reset or
  // while the FIU is almost full.
  always_comb begin
    elig    = '0;
    rsp_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i]    = ch_req_valid[i] && (out_cnt_q[i] < MAX_OUT_C);
      rsp_hit[i] = resp_wr_valid && (resp_ch == CH_W'(i));
    end
    req_vec = (reset || !req_wr_available) ? '0 : elig;
  end

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req_i (req_vec),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign ch_req_ready = gnt;

  // Credit bookkeeping: grant adds, response removes, both together cancel;
  // a response against an empty counter is a protocol error and is absorbed.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (gnt[i] && !rsp_hit[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + 8'd1;
      end else if (!gnt[i] && rsp_hit[i] && (out_cnt_q[i] != '0)) begin
        out_cnt_d[i] = out_cnt_q[i] - 8'd1;
      end
    end
  end

  // Registered CCI request, response acks, credits, pointer and sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) out_cnt_q[i] <= '0;
      ack_q    <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mdata_q  <= '0;
      rr_ptr_q <= '0;
      seq_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) out_cnt_q[i] <= out_cnt_d[i];
      ack_q <= rsp_hit;
      en_q  <= gnt_vld;
      if (gnt_vld) begin
        addr_q   <= ch_req_addr[gnt_idx*ADDR_W +: ADDR_W];
        data_q   <= ch_req_data[gnt_idx*CL_DATA_W +: CL_DATA_W];
        mdata_q  <= {seq_q, gnt_idx};
        seq_q    <= seq_q + SEQ_W'(1);
        rr_ptr_q <= gnt_idx + CH_W'(1);
      end
    end
  end

  // Busy flags mirror non-zero credit counters.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_busy[i] = (out_cnt_q[i] != '0);
  end

  assign req_wr_en    = en_q;
  assign req_wr_addr  = addr_q;
  assign req_wr_data  = data_q;
  assign req_wr_mdata = mdata_q;
  assign ch_wr_ack    = ack_q;

`ifdef WR_ARB_STATS_EN
  logic [STATS_W-1:0] stats_q [NUM_CH];

  // Per-channel grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) stats_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt[i] && (stats_q[i] != '1)) stats_q[i] <= stats_q[i] + STATS_W'(1);
      end
    end
  end

  // Flatten counters onto the stats bus.
  always_comb begin
    stats = '0;
    for (int i = 0; i < NUM_CH; i++) stats[i*STATS_W +: STATS_W] = stats_q[i];
  end
`else
  assign stats = '0;
`endif

endmodule
